vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync-pulse pixels.
REQ-004 Parameter H_BP, 48, horizontal back-porch pixels; SHALL be >=1.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front-porch lines.
REQ-007 Parameter V_SYNC, 2, vertical sync-pulse lines.
REQ-008 Parameter V_BP, 33, vertical back-porch lines; SHALL be >=1.
REQ-009 Parameter H_POL, 0, hsync asserted level (0 = active-low).
REQ-010 Parameter V_POL, 0, vsync asserted level (0 = active-low).
REQ-011 Parameter CW, 11, counter/coordinate width; SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-012 clk  in  1  pixel-rate clock; all state changes on its rising edge.
REQ-013 rst  in  1  reset, asynchronous, active-high.
REQ-014 ce  in  1  advance enable (pixel data ready); 0 stalls the block.
REQ-015 hsync  out  1  horizontal sync, polarity H_POL.
REQ-016 vsync  out  1  vertical sync, polarity V_POL.
REQ-017 de  out  1  display enable, 1 inside the active area.
REQ-018 x  out  CW  active pixel column, 0 outside the active area.
REQ-019 y  out  CW  active line row, 0 outside the active area.
REQ-020 line_start  out  1  one-cycle pulse at h_cnt=0.
REQ-021 frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0.

Function
REQ-022 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; line order active, front porch, sync, back porch.
REQ-023 Internal h_cnt counts 0..H_TOTAL-1 and increments only on a clk edge with ce=1.
REQ-024 h_cnt at H_TOTAL-1 with ce=1 wraps to 0, and v_cnt increments in the same edge.
REQ-025 v_cnt at V_TOTAL-1 with h_cnt at H_TOTAL-1 and ce=1 wraps to 0.
REQ-026 All outputs SHALL be flop outputs; no combinational path from counters or ce to any output.
REQ-027 All outputs SHALL describe the current (h_cnt, v_cnt) in the same cycle: decode from next-state values, zero-cycle skew to the counters.
REQ-028 de = 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-029 x = h_cnt and y = v_cnt when de=1; both 0 when de=0.
REQ-030 hsync asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking.
REQ-031 vsync asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, switching only at h_cnt=0.
REQ-032 line_start and frame_start are high only for the first ce=1 cycle at their position, and 0 during any stall cycle.
REQ-033 With ce=0, counters, hsync, vsync, de, x and y hold their values.
REQ-034 ce toggling every cycle SHALL advance exactly one position per ce=1 edge; no skipped or repeated positions.

Reset
REQ-035 rst=1 immediately sets h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, independent of clk.
REQ-036 During reset: de=0, x=0, y=0, hsync and vsync deasserted, line_start=0, frame_start=0.
REQ-037 The first ce=1 edge after reset release moves to (0,0) with de=1, line_start=1, frame_start=1.
REQ-038 Reset asserted mid-frame or mid-stall SHALL abort immediately to the REQ-035/036 state.

Verification
REQ-039 Defaults, ce=1 constantly -> frame_start period 420000 clk; line_start period 800; de high 307200 cycles per frame.
REQ-040 Defaults, ce=1 -> hsync low exactly for h_cnt 656..751; vsync low exactly for lines 490..491.
REQ-041 Defaults -> x runs 0..639 then 0; y runs 0..479; at h_cnt=639, v_cnt=479: x=639, y=479, de=1.
REQ-042 ce=0 held 50 cycles at h_cnt=100, v_cnt=5 -> all outputs frozen, x=100, y=5, de=1; the next ce=1 edge gives x=101.
REQ-043 rst pulsed at h_cnt=700 between clock edges -> outputs reach reset values before the next edge; the first ce=1 edge after release gives frame_start=1, x=0, y=0.
REQ-044 Parameters H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1 -> line period 14, frame period 98 ce edges, hsync high at h_cnt 10..12.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator and its consumer.
// Carries the advance enable in and the registered sync/position outputs back.
// master = timing generator side, slave = pixel pipeline side.
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic          ce;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  ce,
        output hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        output ce,
        input  hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v position counters with sync, de and coordinate outputs.
// Latency: outputs are registered and describe the counter position they sit at (zero skew).
// Backpressure: ce=0 freezes counters and outputs; start pulses drop to 0 on stall cycles.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,   // must be >= 1 so the reset position is outside sync
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,   // must be >= 1 so the reset position is outside sync
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 11
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_gen_if.master   vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Next raster position: advance one pixel per ce edge, wrap line then frame.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (vif.ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Output decode from the next position so registered outputs line up with the counters.
    // vsync follows v_cnt_d, which only moves on the h wrap, so it switches at h_cnt=0.
    always_comb begin
        de_d          = (h_cnt_d < H_ACT_C) && (v_cnt_d < V_ACT_C);
        x_d           = de_d ? h_cnt_d : '0;
        y_d           = de_d ? v_cnt_d : '0;
        hsync_d       = ((h_cnt_d >= HS_BEG_C) && (h_cnt_d < HS_END_C)) ? H_POL : ~H_POL;
        vsync_d       = ((v_cnt_d >= VS_BEG_C) && (v_cnt_d < VS_END_C)) ? V_POL : ~V_POL;
        line_start_d  = vif.ce && (h_cnt_d == '0);
        frame_start_d = line_start_d && (v_cnt_d == '0);
    end

    // State and output registers; reset parks at the last position so the first ce lands on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
endmodule
